// File: rtl/grid_display_scan.sv
// 8x8 row-multiplexed LED scanner with a 1-deep pending grid buffer and tear-free frame-boundary swap.
// Optional GRID_DISPLAY_POPCOUNT_EN adds live_count, the number of live cells in the displayed grid.
module grid_display_scan #(
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] grid,
    input  logic        frame_valid,
    output logic        frame_ready,
    input  logic        enable,
    output logic [7:0]  row_sel,
    output logic [7:0]  col_data,
    output logic        frame_done
`ifdef GRID_DISPLAY_POPCOUNT_EN
    ,
    output logic [6:0]  live_count
`endif
);
    localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t        state, state_n;
    logic [2:0]    row, row_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          swap;
    logic          accept;
    logic          show_n;
    logic          pending_full, shadow_valid;
    logic [63:0]   pending, shadow;

    assign frame_ready = !pending_full;
    assign accept      = frame_valid && frame_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            row   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            row   <= row_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        row_n   = row;
        cnt_n   = cnt;
        swap    = 1'b0;
        if (!enable) begin
            state_n = IDLE;
            row_n   = '0;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pending_full || shadow_valid) begin
                        state_n = BLANK;
                        row_n   = '0;
                        cnt_n   = '0;
                        swap    = pending_full;
                    end
                end
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state_n = SHOW;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                SHOW: begin
                    if (cnt == DWELL_LAST) begin
                        state_n = BLANK;
                        cnt_n   = '0;
                        // 3-bit row wraps 7->0 here; row 7 end is the only tear-free swap point
                        row_n   = row + 3'd1;
                        swap    = (row == 3'd7) && pending_full;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                    row_n   = '0;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // Outputs are registered from the next-state decode so they line up with the state they describe.
    assign show_n = (state_n == SHOW);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_sel    <= '0;
            col_data   <= '0;
            frame_done <= 1'b0;
        end else begin
            row_sel    <= show_n ? (8'd1 << row_n) : 8'd0;
            col_data   <= show_n ? shadow[{row_n, 3'b000} +: 8] : 8'd0;
            frame_done <= show_n && (row_n == 3'd7) && (cnt_n == DWELL_LAST);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_full <= 1'b0;
            shadow_valid <= 1'b0;
            pending      <= '0;
            shadow       <= '0;
        end else begin
            // accept and swap are exclusive: accept needs !pending_full, swap needs pending_full
            if (accept) begin
                pending      <= grid;
                pending_full <= 1'b1;
            end else if (swap) begin
                pending_full <= 1'b0;
            end
            if (swap) begin
                shadow       <= pending;
                shadow_valid <= 1'b1;
            end
        end
    end

`ifdef GRID_DISPLAY_POPCOUNT_EN
    logic [6:0] ones;

    always_comb begin
        ones = '0;
        for (int i = 0; i < 64; i++) ones = ones + 7'(shadow[i]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) live_count <= '0;
        else        live_count <= ones;
    end
`endif

endmodule

// File: doc/grid_display_scan.md
Name: grid_display_scan

Overview:
- Downstream consumer of the 64-bit life-generation register value; drives an 8x8 row-multiplexed LED matrix.
- Accepts a new grid over a valid/ready handshake into a 1-deep pending buffer.
- Swaps the pending grid into a display shadow only at frame boundaries, so the display never tears.
- Scans rows 0..7, with a blanking gap before each row to suppress ghosting.

Parameters:
DWELL_CYCLES, 1000, clock cycles each row is lit (>=1)
BLANK_CYCLES, 16, clock cycles all outputs are dark before each row (>=1)

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset (0 = reset)
grid  input  64  cell states; bit 8*r+c = row r, column c; 1 = live
frame_valid  input  1  grid holds a new generation
frame_ready  output  1  pending buffer empty; transfer when frame_valid && frame_ready
enable  input  1  display on; 0 forces dark immediately
row_sel  output  8  one-hot active row, active-high
col_data  output  8  column drive for active row; col_data[c] = shadow[8*r+c]
frame_done  output  1  one-cycle pulse on the last SHOW cycle of row 7

Behaviour:
- Reset asserted (reset=0), asynchronously clears:
  - state=IDLE, row index=0, dwell/blank counter=0
  - pending_full=0, shadow_valid=0, pending=0, shadow=0
  - row_sel=0, col_data=0, frame_done=0
  - frame_ready=1 (it is simply !pending_full)
- Reset mid-scan: outputs go dark in the same cycle, with no waiting for a clock edge.
- Accept: on a clk edge with frame_valid && frame_ready, pending<=grid and pending_full<=1.
  - frame_valid while !frame_ready is ignored; the source must hold it.
- States: IDLE, BLANK, SHOW. Outputs are registered.
  - row_sel/col_data are nonzero only in SHOW.
- IDLE: exits when enable && (pending_full || shadow_valid).
  - If pending_full: shadow<=pending, pending_full<=0, shadow_valid<=1.
  - Go to BLANK, row=0, counter=0.
- BLANK: counts BLANK_CYCLES cycles, then goes to SHOW with counter=0.
- SHOW: row_sel=1<<row; col_data=shadow[8*row +: 8]; counts DWELL_CYCLES cycles.
  - On the last cycle with row<7: row<=row+1, go to BLANK.
  - On the last cycle with row==7: frame_done=1 for that cycle. If pending_full, swap into shadow on that edge. row<=0, go to BLANK.
- Frame period = 8*(BLANK_CYCLES+DWELL_CYCLES) cycles.
- Latency, IDLE case: frame accepted on edge N gives pending_full at N. Shadow is loaded and BLANK entered at edge N+1. First SHOW cycle (row 0) starts at edge N+1+BLANK_CYCLES.
- Boundary swap and new accept in the same cycle cannot collide, because frame_ready=0 while pending_full. frame_ready rises the cycle after the swap.
- enable deasserted in any state: next edge goes to IDLE, outputs 0, row/counter cleared.
  - pending and shadow are retained, and the handshake keeps working.
  - Re-enable restarts at BLANK row 0, swapping the pending grid in first if one is held.
- Counters are sized for max(DWELL_CYCLES, BLANK_CYCLES)-1. Row index is 3 bits and wraps 7->0 only via the row-7 rule.

Optional Feature:
- Macro: GRID_DISPLAY_POPCOUNT_EN.
- With it defined: adds output live_count [6:0], the number of 1 bits in shadow, range 0..64.
  - Registered; updates on the edge after each shadow load.
  - Reset value 0.
- Without it: no port and no adder logic; all other behaviour identical.

Test Plan (DWELL_CYCLES=4, BLANK_CYCLES=2):
- Reset mid-SHOW with row_sel=8'h04 → row_sel=0, col_data=0, frame_ready=1 immediately. After release: IDLE, no output while enable=1 and nothing loaded.
- enable=1, grid=64'h8040201008040201 valid one cycle → row 0 lit after 2 blank cycles with col_data=8'h01 for 4 cycles. Rows 1..7 follow with 8'h02..8'h80 and row_sel one-hot. frame_done pulses once at cycle 48 of the frame.
- During frame A, send frame B=64'hFFFF... then hold frame_valid with C=64'h0F... → B accepted and frame_ready=0. C stalls until the row-7 boundary swap. Next frame shows B rows=8'hFF; C is accepted one cycle after the swap.
- No new frames after one load → shadow rescans indefinitely; frame_done every 48 cycles.
- enable dropped during row 3 SHOW → dark next cycle. Re-enable restarts at BLANK row 0 with the same shadow.
- Popcount build: load 64'h00000000000000FF → live_count=8 one edge after load; load 64'hFFFFFFFFFFFFFFFF → 64.
